// File: rtl/stopwatch_pkg.sv
// Shared definitions for the mm:ss stopwatch.
// Contents:
//   mode_e     - 2-bit operating mode, also the externally visible `mode` code
//   MASK_*     - per-digit blank masks for the seven-segment scan driver
//   is_adj     - true for either adjust mode
package stopwatch_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_PAUSE   = 2'b01,
        MODE_ADJ_MIN = 2'b10,
        MODE_ADJ_SEC = 2'b11
    } mode_e;

    // bit0 = seconds ones ... bit3 = minutes tens
    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_MIN  = 4'b1100;
    localparam logic [3:0] MASK_SEC  = 4'b0011;

    // Both adjust encodings share the MSB.
    function automatic logic is_adj(input mode_e m);
        return m[1];
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Button synchronizer plus rising-edge pulse generator.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset; clears chain and edge history
//   btn    - debounced (asynchronous) button level
//   rise   - one-cycle pulse when the synchronized level goes 0 -> 1
// SYNC_STAGES must be at least 2.
module btn_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // History resets to 0, so a button held through reset yields one edge.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/stopwatch_mode_ctrl.sv
// Stopwatch mode controller: RUN/PAUSE/ADJ_MIN/ADJ_SEC state machine, tick
// qualification for the time counter and digit blinking for the display.
// Ports:
//   clk, rst_n        - clock and asynchronous active-low reset
//   btn_pause/adj/sel/clr - debounced button levels (asynchronous)
//   tick_1hz, tick_2hz    - single-cycle timebase pulses
//   run_tick          - advance seconds with carry (RUN only)
//   adj_sec_tick      - bump seconds field, no carry (ADJ_SEC only)
//   adj_min_tick      - bump minutes field (ADJ_MIN only)
//   clear             - zero the counter
//   blank_mask        - 1 = blank digit, bit0 = sec ones ... bit3 = min tens
//   mode              - current mode code
// All outputs are registered.
module stopwatch_mode_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pause,
    input  logic       btn_adj,
    input  logic       btn_sel,
    input  logic       btn_clr,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    output logic       run_tick,
    output logic       adj_sec_tick,
    output logic       adj_min_tick,
    output logic       clear,
    output logic [3:0] blank_mask,
    output logic [1:0] mode
);

    logic pause_rise, adj_rise, sel_rise, clr_rise;

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pause (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_pause),
        .rise  (pause_rise)
    );

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_adj (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_adj),
        .rise  (adj_rise)
    );

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_sel),
        .rise  (sel_rise)
    );

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_clr),
        .rise  (clr_rise)
    );

    mode_e      state_q, state_d;
    logic       was_paused_q, was_paused_d;
    logic       phase_q, phase_d;
    logic       run_tick_q, run_tick_d;
    logic       adj_sec_tick_q, adj_sec_tick_d;
    logic       adj_min_tick_q, adj_min_tick_d;
    logic       clear_q, clear_d;
    logic [3:0] blank_mask_q, blank_mask_d;

    // Next-state: adjust beats pause beats select; losers are dropped.
    always_comb begin
        state_d      = state_q;
        was_paused_d = was_paused_q;
        unique case (state_q)
            MODE_RUN, MODE_PAUSE: begin
                if (adj_rise) begin
                    state_d      = MODE_ADJ_MIN;
                    was_paused_d = (state_q == MODE_PAUSE);
                end else if (pause_rise) begin
                    state_d = (state_q == MODE_RUN) ? MODE_PAUSE : MODE_RUN;
                end
            end
            MODE_ADJ_MIN, MODE_ADJ_SEC: begin
                if (adj_rise) begin
                    state_d = was_paused_q ? MODE_PAUSE : MODE_RUN;
                end else if (sel_rise && !pause_rise) begin
                    // An ignored pause edge still wins the cycle over select.
                    state_d = (state_q == MODE_ADJ_MIN) ? MODE_ADJ_SEC : MODE_ADJ_MIN;
                end
            end
            default: state_d = MODE_RUN;
        endcase
    end

    // Blink phase and registered outputs; ticks are qualified by the old state.
    always_comb begin
        phase_d = phase_q;
        if (is_adj(state_d) && (state_d != state_q)) begin
            phase_d = 1'b0;  // entry into an adjust mode or MIN<->SEC switch
        end else if (is_adj(state_q) && tick_2hz) begin
            phase_d = ~phase_q;
        end

        clear_d        = clr_rise;
        run_tick_d     = tick_1hz && (state_q == MODE_RUN) && !clr_rise;
        adj_min_tick_d = tick_2hz && (state_q == MODE_ADJ_MIN) && !clr_rise;
        adj_sec_tick_d = tick_2hz && (state_q == MODE_ADJ_SEC) && !clr_rise;

        blank_mask_d = MASK_NONE;
        if (phase_d) begin
            if (state_d == MODE_ADJ_MIN) begin
                blank_mask_d = MASK_MIN;
            end else if (state_d == MODE_ADJ_SEC) begin
                blank_mask_d = MASK_SEC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= MODE_RUN;
            was_paused_q   <= 1'b0;
            phase_q        <= 1'b0;
            run_tick_q     <= 1'b0;
            adj_sec_tick_q <= 1'b0;
            adj_min_tick_q <= 1'b0;
            clear_q        <= 1'b0;
            blank_mask_q   <= MASK_NONE;
        end else begin
            state_q        <= state_d;
            was_paused_q   <= was_paused_d;
            phase_q        <= phase_d;
            run_tick_q     <= run_tick_d;
            adj_sec_tick_q <= adj_sec_tick_d;
            adj_min_tick_q <= adj_min_tick_d;
            clear_q        <= clear_d;
            blank_mask_q   <= blank_mask_d;
        end
    end

    assign mode         = state_q;
    assign run_tick     = run_tick_q;
    assign adj_sec_tick = adj_sec_tick_q;
    assign adj_min_tick = adj_min_tick_q;
    assign clear        = clear_q;
    assign blank_mask   = blank_mask_q;

endmodule

// File: tb/tb_stopwatch_mode_ctrl.sv
// Scoreboard bench for stopwatch_mode_ctrl. Stimulus pushes the expected
// output event (with the cycle it must appear in); the monitor pops one entry
// whenever the DUT shows a pulse or a mode/blank_mask change.
module tb_stopwatch_mode_ctrl;

    typedef struct packed {
        int         cyc;
        logic [1:0] mode;
        logic [3:0] mask;
        logic       run;
        logic       asec;
        logic       amin;
        logic       clr;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;  // {clr, sel, adj, pause}
    logic       tick_1hz, tick_2hz;
    logic       run_tick, adj_sec_tick, adj_min_tick, clear;
    logic [3:0] blank_mask;
    logic [1:0] mode;

    int  cyc;
    int  n_cmp;
    int  n_bad;
    ev_t q[$];
    ev_t act, exp_e;
    logic [1:0] prev_mode;
    logic [3:0] prev_mask;

    stopwatch_mode_ctrl #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_pause    (btn[0]),
        .btn_adj      (btn[1]),
        .btn_sel      (btn[2]),
        .btn_clr      (btn[3]),
        .tick_1hz     (tick_1hz),
        .tick_2hz     (tick_2hz),
        .run_tick     (run_tick),
        .adj_sec_tick (adj_sec_tick),
        .adj_min_tick (adj_min_tick),
        .clear        (clear),
        .blank_mask   (blank_mask),
        .mode         (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string fmt(input ev_t e);
        return $sformatf("cyc=%0d mode=%b mask=%b run=%b asec=%b amin=%b clr=%b",
                         e.cyc, e.mode, e.mask, e.run, e.asec, e.amin, e.clr);
    endfunction

    function automatic ev_t sample();
        ev_t e;
        e.cyc  = cyc;
        e.mode = mode;
        e.mask = blank_mask;
        e.run  = run_tick;
        e.asec = adj_sec_tick;
        e.amin = adj_min_tick;
        e.clr  = clear;
        return e;
    endfunction

    // Monitor: outputs only move on posedge (or reset), so negedge is stable.
    initial begin
        prev_mode = 2'b00;
        prev_mask = 4'b0000;
    end

    always @(negedge clk) begin
        act = sample();
        if (act.run || act.asec || act.amin || act.clr ||
            act.mode != prev_mode || act.mask != prev_mask) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: actual %s, required no event", fmt(act));
            end else begin
                exp_e = q.pop_front();
                if (act !== exp_e) begin
                    n_bad++;
                    $display("FAIL event: actual %s, required %s", fmt(act), fmt(exp_e));
                end
            end
        end
        prev_mode = act.mode;
        prev_mask = act.mask;
    end

    task automatic push(input int dc, input logic [1:0] m, input logic [3:0] k,
                        input logic r, input logic as, input logic am, input logic c);
        ev_t e;
        e.cyc  = cyc + dc;
        e.mode = m;
        e.mask = k;
        e.run  = r;
        e.asec = as;
        e.amin = am;
        e.clr  = c;
        q.push_back(e);
    endtask

    // One-cycle tick pulse; an expected event lands one cycle after driving.
    task automatic tick(input logic t1, input logic t2, input logic expect_ev,
                        input logic [1:0] m, input logic [3:0] k,
                        input logic r, input logic as, input logic am);
        @(negedge clk);
        tick_1hz = t1;
        tick_2hz = t2;
        if (expect_ev) push(1, m, k, r, as, am, 1'b0);
        @(negedge clk);
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        @(negedge clk);
    endtask

    // Button held for several cycles; its single edge acts 3 cycles after driving.
    task automatic press(input logic [3:0] which, input logic [1:0] m, input logic [3:0] k);
        @(negedge clk);
        btn = which;
        push(3, m, k, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        btn = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        ev_t a, e;
        a = sample();
        e = '0;
        e.cyc = a.cyc;
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: actual %s, required %s", name, fmt(a), fmt(e));
        end
    endtask

    localparam logic [3:0] B_PAUSE = 4'b0001;
    localparam logic [3:0] B_ADJ   = 4'b0010;
    localparam logic [3:0] B_SEL   = 4'b0100;
    localparam logic [3:0] B_CLR   = 4'b1000;

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        btn      = 4'b0000;
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // RUN: three seconds
        repeat (3) tick(1'b1, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0);

        // PAUSE swallows both ticks
        press(B_PAUSE, 2'b01, 4'b0000);
        tick(1'b1, 1'b1, 1'b0, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0);
        press(B_PAUSE, 2'b00, 4'b0000);

        // PAUSE -> ADJ_MIN, blink on tick_2hz
        press(B_PAUSE, 2'b01, 4'b0000);
        press(B_ADJ, 2'b10, 4'b0000);
        tick(1'b0, 1'b1, 1'b1, 2'b10, 4'b1100, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 2'b10, 4'b1100, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 2'b10, 4'b1100, 1'b0, 1'b0, 1'b1);
        // Select clears the blink phase while it is high
        press(B_SEL, 2'b11, 4'b0000);
        tick(1'b0, 1'b1, 1'b1, 2'b11, 4'b0011, 1'b0, 1'b1, 1'b0);
        // Leave adjust: was_paused brings us back to PAUSE
        press(B_ADJ, 2'b01, 4'b0000);
        press(B_PAUSE, 2'b00, 4'b0000);

        // Adjust and pause together from RUN: adjust wins, pause dropped
        press(B_ADJ | B_PAUSE, 2'b10, 4'b0000);
        press(B_ADJ, 2'b00, 4'b0000);

        // Clear coincident with tick_1hz in RUN
        @(negedge clk);
        btn = B_CLR;
        push(3, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        repeat (3) @(negedge clk);
        btn = 4'b0000;
        repeat (2) @(negedge clk);

        // Reach ADJ_SEC with blank_mask=0011, then reset mid-operation
        press(B_ADJ, 2'b10, 4'b0000);
        press(B_SEL, 2'b11, 4'b0000);
        tick(1'b0, 1'b1, 1'b1, 2'b11, 4'b0011, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        btn   = B_ADJ;
        rst_n = 1'b0;
        push(1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // Held adjust produces exactly one edge after release
        push(3, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        btn = 4'b0000;
        repeat (6) @(negedge clk);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: actual %0d outstanding, required 0 (next %s)",
                     q.size(), fmt(q[0]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
